// File: rtl/ps2_key_decoder_if.sv
// Scancode byte stream in, synth control signals out.
// The master drives bytes; the slave (the decoder) returns note and pulses.
interface ps2_key_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [3:0] note;
  logic       note_in;
  logic       octave_plus_plus;
  logic       octave_minus_minus;
  logic       amp_plus_plus;
  logic       amp_minus_minus;

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  note, note_in, octave_plus_plus, octave_minus_minus,
           amp_plus_plus, amp_minus_minus
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output note, note_in, octave_plus_plus, octave_minus_minus,
           amp_plus_plus, amp_minus_minus
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: make/break and E0 prefix handling, note tracking,
// and one-pulse-per-press control keys with typematic repeat suppression.
//
// state     | meaning
// IDLE      | no prefix pending; next plain byte is a make
// GOT_E0    | E0 seen; next plain byte is an extended make
// GOT_F0    | F0 seen; next plain byte is a break
// GOT_E0F0  | E0 F0 seen; next plain byte is an extended break
module ps2_key_decoder #(
  parameter int PREFIX_TIMEOUT = 2500000,
  parameter int TO_W           = 22
) (
  input  logic                clk,
  input  logic                reset,
  ps2_key_decoder_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(PREFIX_TIMEOUT);

  // Control key slots: 0 octave down, 1 octave up, 2 amp up, 3 amp down
  localparam int K_OMM = 0;
  localparam int K_OPP = 1;
  localparam int K_APP = 2;
  localparam int K_AMM = 3;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [3:0]      note_q, note_nxt;
  logic            note_in_q, note_in_nxt;
  logic [3:0]      held_q, held_nxt;
  logic [3:0]      pulse_q, pulse_nxt;

  logic            is_ext;
  logic            is_brk;
  logic            code_is_note;
  logic [3:0]      code_note;
  logic [3:0]      code_ctl;

  assign is_ext = (state == GOT_E0) || (state == GOT_E0F0);
  assign is_brk = (state == GOT_F0) || (state == GOT_E0F0);

  always_comb begin
    code_is_note = 1'b0;
    code_note    = 4'd0;
    code_ctl     = 4'b0000;
    if (!is_ext) begin
      code_is_note = 1'b1;
      case (bus.ps2_byte)
        8'h1C:   code_note = 4'd0;
        8'h1D:   code_note = 4'd1;
        8'h1B:   code_note = 4'd2;
        8'h24:   code_note = 4'd3;
        8'h23:   code_note = 4'd4;
        8'h2B:   code_note = 4'd5;
        8'h2C:   code_note = 4'd6;
        8'h34:   code_note = 4'd7;
        8'h35:   code_note = 4'd8;
        8'h33:   code_note = 4'd9;
        8'h3C:   code_note = 4'd10;
        8'h3B:   code_note = 4'd11;
        8'h42:   code_note = 4'd12;
        default: code_is_note = 1'b0;
      endcase
      case (bus.ps2_byte)
        8'h1A:   code_ctl[K_OMM] = 1'b1;
        8'h22:   code_ctl[K_OPP] = 1'b1;
        default: code_ctl = 4'b0000;
      endcase
    end else begin
      case (bus.ps2_byte)
        8'h75:   code_ctl[K_APP] = 1'b1;
        8'h72:   code_ctl[K_AMM] = 1'b1;
        default: code_ctl = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    note_nxt    = note_q;
    note_in_nxt = note_in_q;
    held_nxt    = held_q;
    pulse_nxt   = 4'b0000;

    if (bus.ps2_byte_valid) begin
      to_cnt_nxt = '0;
      if (bus.ps2_byte == CODE_E0) begin
        state_nxt = GOT_E0;
      end else if (bus.ps2_byte == CODE_F0) begin
        case (state)
          IDLE:    state_nxt = GOT_F0;
          GOT_E0:  state_nxt = GOT_E0F0;
          default: state_nxt = state;
        endcase
      end else begin
        state_nxt = IDLE;
        if (code_is_note) begin
          if (!is_brk) begin
            note_nxt    = code_note;
            note_in_nxt = 1'b1;
          end else if (code_note == note_q) begin
            note_in_nxt = 1'b0;
          end
        end
        // A held control key re-sends its make while down; only the first one pulses
        if (is_brk) begin
          held_nxt = held_q & ~code_ctl;
        end else begin
          pulse_nxt = code_ctl & ~held_q;
          held_nxt  = held_q | code_ctl;
        end
      end
    end else if (state != IDLE) begin
      if (to_cnt == TO_LIMIT) begin
        state_nxt  = IDLE;
        to_cnt_nxt = '0;
      end else begin
        to_cnt_nxt = to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      to_cnt    <= '0;
      note_q    <= 4'd0;
      note_in_q <= 1'b0;
      held_q    <= 4'b0000;
      pulse_q   <= 4'b0000;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_cnt_nxt;
      note_q    <= note_nxt;
      note_in_q <= note_in_nxt;
      held_q    <= held_nxt;
      pulse_q   <= pulse_nxt;
    end
  end

  assign bus.note               = note_q;
  assign bus.note_in            = note_in_q;
  assign bus.octave_minus_minus = pulse_q[K_OMM];
  assign bus.octave_plus_plus   = pulse_q[K_OPP];
  assign bus.amp_plus_plus      = pulse_q[K_APP];
  assign bus.amp_minus_minus    = pulse_q[K_AMM];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scancode sequences, a sequence-level
// reference model compared every cycle, and literal spot checks.
module tb_ps2_key_decoder;
  localparam int PT = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.PREFIX_TIMEOUT(PT), .TO_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending prefix flags plus held-key set, evaluated per byte
  logic [7:0] note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                  8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  int  cyc = 0;
  int  pref_cyc = 0;
  bit  model_ready = 0;
  bit  m_ext = 0, m_brk = 0;
  int  m_note = 0;
  bit  m_in = 0;
  bit  m_hold [4];
  bit  m_pulse [4];

  always @(posedge clk) begin
    logic [7:0] b;
    int idx, k;
    cyc++;
    for (int i = 0; i < 4; i++) m_pulse[i] = 0;
    if (!reset) begin
      m_note = 0; m_in = 0; m_ext = 0; m_brk = 0;
      for (int i = 0; i < 4; i++) m_hold[i] = 0;
      model_ready = 1;
    end else if (bus.ps2_byte_valid) begin
      b = bus.ps2_byte;
      if ((m_ext || m_brk) && (cyc - pref_cyc > PT + 1)) begin
        m_ext = 0; m_brk = 0;
      end
      pref_cyc = cyc;
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else begin
        idx = -1;
        for (int i = 0; i < 13; i++) if (note_codes[i] == b) idx = i;
        if (!m_ext && idx >= 0) begin
          if (!m_brk) begin m_note = idx; m_in = 1; end
          else if (idx == m_note) m_in = 0;
        end
        k = -1;
        if (!m_ext && b == 8'h1A) k = 0;
        if (!m_ext && b == 8'h22) k = 1;
        if (m_ext && b == 8'h75)  k = 2;
        if (m_ext && b == 8'h72)  k = 3;
        if (k >= 0) begin
          if (m_brk) m_hold[k] = 0;
          else if (!m_hold[k]) begin m_hold[k] = 1; m_pulse[k] = 1; end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  end

  int n_opp = 0, n_omm = 0, n_app = 0, n_amm = 0;

  always @(negedge clk) begin
    if (model_ready) begin
      chk("note", int'(bus.note), m_note);
      chk("note_in", int'(bus.note_in), int'(m_in));
      chk("octave_minus_minus", int'(bus.octave_minus_minus), int'(m_pulse[0]));
      chk("octave_plus_plus", int'(bus.octave_plus_plus), int'(m_pulse[1]));
      chk("amp_plus_plus", int'(bus.amp_plus_plus), int'(m_pulse[2]));
      chk("amp_minus_minus", int'(bus.amp_minus_minus), int'(m_pulse[3]));
    end
    n_opp += int'(bus.octave_plus_plus === 1'b1);
    n_omm += int'(bus.octave_minus_minus === 1'b1);
    n_app += int'(bus.amp_plus_plus === 1'b1);
    n_amm += int'(bus.amp_minus_minus === 1'b1);
  end

  // Called at posedge+1; leaves the bench at posedge+1 after the byte is captured
  task automatic send(input logic [7:0] b);
    bus.ps2_byte = b;
    bus.ps2_byte_valid = 1'b1;
    @(posedge clk); #1;
    bus.ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.ps2_byte = 8'h00;
    bus.ps2_byte_valid = 1'b0;
    reset = 1'b0;
    idle(3);
    chk("reset_note", int'(bus.note), 0);
    chk("reset_note_in", int'(bus.note_in), 0);
    reset = 1'b1;
    idle(2);

    // 1: make then break of A
    send(8'h1C);
    chk("t1_make_note", int'(bus.note), 0);
    chk("t1_make_in", int'(bus.note_in), 1);
    send(8'hF0); send(8'h1C);
    chk("t1_break_in", int'(bus.note_in), 0);
    chk("t1_break_note", int'(bus.note), 0);
    idle(2);

    // 2: last key wins; break of the older key is ignored
    send(8'h1C); send(8'h23);
    chk("t2_note", int'(bus.note), 4);
    chk("t2_in", int'(bus.note_in), 1);
    send(8'hF0); send(8'h1C);
    chk("t2_oldbreak_note", int'(bus.note), 4);
    chk("t2_oldbreak_in", int'(bus.note_in), 1);
    send(8'hF0); send(8'h23);
    chk("t2_break_in", int'(bus.note_in), 0);
    idle(2);

    // 3: typematic repeats of X
    base = n_opp;
    send(8'h22);
    chk("t3_first_pulse", int'(bus.octave_plus_plus), 1);
    send(8'h22);
    chk("t3_repeat_nopulse", int'(bus.octave_plus_plus), 0);
    send(8'h22); send(8'hF0); send(8'h22); send(8'h22);
    chk("t3_last_pulse", int'(bus.octave_plus_plus), 1);
    idle(3);
    chk("t3_pulse_count", n_opp - base, 2);

    // 4: arrows, plus codes that must be ignored
    base = n_app;
    send(8'hE0); send(8'h75);
    chk("t4_amp_up", int'(bus.amp_plus_plus), 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h72);
    chk("t4_amp_down", int'(bus.amp_minus_minus), 1);
    send(8'h75); send(8'hE0); send(8'h1C);
    send(8'hAA); send(8'hFA);
    chk("t4_ignored_note", int'(bus.note), 4);
    chk("t4_ignored_in", int'(bus.note_in), 0);
    idle(3);
    chk("t4_amp_up_count", n_app - base, 1);
    chk("t4_amp_down_count", n_amm, 1);

    // 5: prefix timeout, then prefix inside the window
    send(8'hF0);
    idle(PT + 2);
    send(8'h1C);
    chk("t5_timeout_make_note", int'(bus.note), 0);
    chk("t5_timeout_make_in", int'(bus.note_in), 1);
    send(8'hF0);
    idle(49);
    send(8'h1C);
    chk("t5_window_break_in", int'(bus.note_in), 0);
    idle(2);

    // 6: reset mid-sequence with a simultaneous strobe
    send(8'h23);
    chk("t6_pre_in", int'(bus.note_in), 1);
    send(8'hE0);
    base = n_app;
    bus.ps2_byte = 8'h75;
    bus.ps2_byte_valid = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus.ps2_byte_valid = 1'b0;
    reset = 1'b1;
    chk("t6_reset_note", int'(bus.note), 0);
    chk("t6_reset_in", int'(bus.note_in), 0);
    chk("t6_reset_amp", int'(bus.amp_plus_plus), 0);
    idle(1);
    base = n_omm;
    send(8'h1A);
    chk("t6_omm_pulse", int'(bus.octave_minus_minus), 1);
    idle(3);
    chk("t6_omm_count", n_omm - base, 1);
    chk("t6_amp_count", n_app, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
